// File: rtl/pc_seq_gen_if.sv
// pc_seq_gen_if: fetch-side bus between the redirect logic and the PC sequencer.
//   Redirect/stall inputs : stall, bt, jt_j, jt_r, imm_b, imm_j, jlr
//   PC outputs            : pc_out, pc_valid, misalign, bad_addr
//   modport master : the decode/execute redirect side (drives redirects, sees the PC)
//   modport slave  : the sequencer (sees redirects, drives the PC)
interface pc_seq_gen_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall;
   logic            bt;
   logic            jt_j;
   logic            jt_r;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] jlr;
   logic [XLEN-1:0] pc_out;
   logic            pc_valid;
   logic            misalign;
   logic [XLEN-1:0] bad_addr;

   modport master (
      output stall, bt, jt_j, jt_r, imm_b, imm_j, jlr,
      input  pc_out, pc_valid, misalign, bad_addr
   );

   modport slave (
      input  stall, bt, jt_j, jt_r, imm_b, imm_j, jlr,
      output pc_out, pc_valid, misalign, bad_addr
   );
endinterface

// File: rtl/pc_seq_gen.sv
// pc_seq_gen: program-counter sequencer for the fetch stage.
//   Holds the PC and each RUN cycle applies jalr > jal > branch > sequential step. Supports
//   start/halt control, fetch stall with a one-entry pending-redirect buffer, a misaligned
//   redirect-target trap and configurable reset/trap vectors.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   start      leave IDLE/HALT and begin issuing PCs
//   halt       stop issuing after the current update
//   bus        pc_seq_gen_if.slave (redirect/stall inputs, pc_out/pc_valid/misalign/bad_addr)
//   redir_cnt  applied redirects (incl. pending and trapped)
//   stall_cnt  RUN cycles with stall=1
// Build option: define PC_SEQ_PERF_EN to build the saturating redir_cnt/stall_cnt counters;
// otherwise both ports are tied to zero.
module pc_seq_gen #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     STEP       = 1,
   parameter int unsigned     ALIGN_BITS = 0,
   parameter logic [XLEN-1:0] RESET_VEC  = '0,
   parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(4)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        halt,
   pc_seq_gen_if.slave bus,
   output logic [31:0] redir_cnt,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt, StTrap} state_e;

   // Low target bits that must be zero; an all-zero mask disables the check.
   localparam logic [XLEN-1:0] AlignMask =
      (ALIGN_BITS == 0) ? '0 : ((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

   state_e          state_q;
   logic [XLEN-1:0] pc_q;
   logic            valid_q;
   logic            mis_q;
   logic [XLEN-1:0] bad_q;
   logic            pend_v_q;
   logic [XLEN-1:0] pend_tgt_q;

   logic            live_redir;
   logic [XLEN-1:0] live_tgt;
   logic            use_redir;
   logic [XLEN-1:0] redir_tgt;
   logic            tgt_bad;
   logic [XLEN-1:0] seq_pc;

   // Highest-priority live redirect, computed from the held PC.
   always_comb begin
      live_redir = bus.jt_r | bus.jt_j | bus.bt;
      live_tgt   = '0;
      if (bus.jt_r) begin
         live_tgt = bus.jlr;
      end else if (bus.jt_j) begin
         live_tgt = pc_q + bus.imm_j;
      end else if (bus.bt) begin
         live_tgt = pc_q + bus.imm_b;
      end
   end

   // On a non-stall cycle a live redirect beats the buffered one.
   assign use_redir = live_redir | pend_v_q;
   assign redir_tgt = live_redir ? live_tgt : pend_tgt_q;
   assign tgt_bad   = |(redir_tgt & AlignMask);
   assign seq_pc    = pc_q + XLEN'(STEP);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         pc_q       <= RESET_VEC;
         valid_q    <= 1'b0;
         mis_q      <= 1'b0;
         bad_q      <= '0;
         pend_v_q   <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         mis_q <= 1'b0;
         case (state_q)
            StIdle, StHalt: begin
               if (start) begin
                  state_q <= StRun;
                  valid_q <= 1'b1;
               end
            end
            StTrap: begin
               state_q <= StRun;
               valid_q <= 1'b1;
            end
            StRun: begin
               if (bus.stall) begin
                  if (live_redir) begin
                     pend_v_q   <= 1'b1;
                     pend_tgt_q <= live_tgt;
                  end
                  if (halt) begin
                     // Entering HALT drops any buffered redirect.
                     state_q  <= StHalt;
                     valid_q  <= 1'b0;
                     pend_v_q <= 1'b0;
                  end
               end else begin
                  pend_v_q <= 1'b0;
                  if (use_redir && tgt_bad) begin
                     pc_q    <= TRAP_VEC;
                     bad_q   <= redir_tgt;
                     mis_q   <= 1'b1;
                     state_q <= StTrap;
                     valid_q <= 1'b0;
                  end else begin
                     pc_q <= use_redir ? redir_tgt : seq_pc;
                     if (halt) begin
                        state_q <= StHalt;
                        valid_q <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc_out   = pc_q;
   assign bus.pc_valid = valid_q;
   assign bus.misalign = mis_q;
   assign bus.bad_addr = bad_q;

`ifdef PC_SEQ_PERF_EN
   logic [31:0] redir_cnt_q;
   logic [31:0] stall_cnt_q;
   logic        redir_fire;
   logic        stall_fire;

   assign redir_fire = (state_q == StRun) && !bus.stall && use_redir;
   assign stall_fire = (state_q == StRun) && bus.stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         redir_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (redir_fire && (redir_cnt_q != 32'hFFFF_FFFF)) begin
            redir_cnt_q <= redir_cnt_q + 32'd1;
         end
         if (stall_fire && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign redir_cnt = redir_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   assign redir_cnt = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_seq_gen.sv
// tb_pc_seq_gen: scoreboard bench for pc_seq_gen. Instance a uses STEP=1 with no alignment
// check; instance b uses STEP=4, ALIGN_BITS=2 for the misaligned-target trap.
module tb_pc_seq_gen;

   logic        clock;
   logic        reset;
   logic        start_a, halt_a, start_b, halt_b;
   logic [31:0] redir_a, stall_a, redir_b, stall_b;

   pc_seq_gen_if #(.XLEN(32)) bus_a ();
   pc_seq_gen_if #(.XLEN(32)) bus_b ();

   pc_seq_gen #(.XLEN(32), .STEP(1), .ALIGN_BITS(0)) dut_a (
      .clock     (clock),
      .reset     (reset),
      .start     (start_a),
      .halt      (halt_a),
      .bus       (bus_a),
      .redir_cnt (redir_a),
      .stall_cnt (stall_a)
   );

   pc_seq_gen #(.XLEN(32), .STEP(4), .ALIGN_BITS(2)) dut_b (
      .clock     (clock),
      .reset     (reset),
      .start     (start_b),
      .halt      (halt_b),
      .bus       (bus_b),
      .redir_cnt (redir_b),
      .stall_cnt (stall_b)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      string       tag;
      bit          sel;
      logic [31:0] pc;
      logic        valid;
      logic        mis;
      logic [31:0] bad;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          cur_sel = 1'b0;
   logic [31:0] exp_bad = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PC_SEQ_PERF_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   // Called at a negedge with inputs set: queue what the next posedge must produce.
   task automatic tick(input string tag, input logic [31:0] pc, input logic v,
                       input logic m = 1'b0);
      exp_t e;
      e.tag   = tag;
      e.sel   = cur_sel;
      e.pc    = pc;
      e.valid = v;
      e.mis   = m;
      e.bad   = exp_bad;
      sb.push_back(e);
      @(negedge clock);
   endtask

   task automatic clr_bus();
      bus_a.stall = 0; bus_a.bt = 0; bus_a.jt_j = 0; bus_a.jt_r = 0;
      bus_a.imm_b = '0; bus_a.imm_j = '0; bus_a.jlr = '0;
      bus_b.stall = 0; bus_b.bt = 0; bus_b.jt_j = 0; bus_b.jt_r = 0;
      bus_b.imm_b = '0; bus_b.imm_j = '0; bus_b.jlr = '0;
   endtask

   // Monitor: compare just after each active edge.
   exp_t        cur;
   logic [31:0] o_pc, o_bad;
   logic        o_v, o_m;
   always begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         if (cur.sel) begin
            o_pc = bus_b.pc_out; o_v = bus_b.pc_valid; o_m = bus_b.misalign; o_bad = bus_b.bad_addr;
         end else begin
            o_pc = bus_a.pc_out; o_v = bus_a.pc_valid; o_m = bus_a.misalign; o_bad = bus_a.bad_addr;
         end
         check({cur.tag, ".pc"}, o_pc, cur.pc);
         check({cur.tag, ".valid"}, 32'(o_v), 32'(cur.valid));
         check({cur.tag, ".misalign"}, 32'(o_m), 32'(cur.mis));
         check({cur.tag, ".bad_addr"}, o_bad, cur.bad);
      end
   end

   initial begin
      reset = 1; start_a = 0; halt_a = 0; start_b = 0; halt_b = 0;
      clr_bus();
      tick("rst0", 0, 0);
      tick("rst1", 0, 0);
      check("rst_redir_cnt", redir_a, 32'd0);
      check("rst_stall_cnt", stall_a, 32'd0);

      // Start and sequential stepping.
      reset = 0; start_a = 1;
      tick("t1_first", 0, 1);
      start_a = 0;
      for (int i = 1; i <= 10; i++) tick("t1_seq", i, 1);

      // jal beats branch; jalr beats jal.
      bus_a.bt = 1; bus_a.imm_b = 32'hFFFF_FFFD; bus_a.jt_j = 1; bus_a.imm_j = 32'd8;
      tick("t2_jal_over_br", 18, 1);
      bus_a.jt_r = 1; bus_a.jlr = 32'd20;
      tick("t2_jalr_over_jal", 20, 1);

      // Stall with a redirect buffered in stall cycle 2.
      clr_bus(); bus_a.stall = 1;
      tick("t3_stall1", 20, 1);
      bus_a.jt_r = 1; bus_a.jlr = 32'd100;
      tick("t3_stall2", 20, 1);
      bus_a.jt_r = 0;
      tick("t3_stall3", 20, 1);
      bus_a.stall = 0;
      tick("t3_release", 100, 1);
      check("t3_stall_cnt", stall_a, perf(3));
      check("t3_redir_cnt", redir_a, perf(3));

      // Live redirect on release beats pending; pending then cleared.
      bus_a.stall = 1; bus_a.bt = 1; bus_a.imm_b = 32'd5;
      tick("pend_hold", 100, 1);
      bus_a.stall = 0; bus_a.bt = 0; bus_a.jt_j = 1; bus_a.imm_j = 32'hFFFF_FFCE;
      tick("live_beats_pend", 50, 1);
      clr_bus();
      tick("pend_cleared", 51, 1);

      // Latest buffered redirect wins.
      bus_a.stall = 1; bus_a.bt = 1; bus_a.imm_b = 32'd2;
      tick("latest_1", 51, 1);
      bus_a.bt = 0; bus_a.jt_r = 1; bus_a.jlr = 32'd7;
      tick("latest_2", 51, 1);
      clr_bus();
      tick("latest_wins", 7, 1);
      check("pend_stall_cnt", stall_a, perf(6));
      check("pend_redir_cnt", redir_a, perf(5));

      // Wrap-around.
      bus_a.jt_r = 1; bus_a.jlr = 32'hFFFF_FFFF;
      tick("t5_to_max", 32'hFFFF_FFFF, 1);
      clr_bus();
      tick("t5_seq_wrap", 0, 1);
      bus_a.bt = 1; bus_a.imm_b = 32'hFFFF_FFFF;
      tick("br_neg_wrap", 32'hFFFF_FFFF, 1);
      bus_a.imm_b = 32'd2;
      tick("br_pos_wrap", 1, 1);

      // Halt together with a branch.
      clr_bus(); bus_a.jt_r = 1; bus_a.jlr = 32'd8;
      tick("t6_to8", 8, 1);
      clr_bus(); halt_a = 1; bus_a.bt = 1; bus_a.imm_b = 32'd4;
      tick("t6_halt_br", 12, 0);
      halt_a = 0; bus_a.stall = 1;
      tick("halt_ignore1", 12, 0);
      tick("halt_ignore2", 12, 0);
      check("halt_stall_cnt", stall_a, perf(6));
      check("halt_redir_cnt", redir_a, perf(10));
      clr_bus(); start_a = 1;
      tick("halt_restart", 12, 1);
      start_a = 0;
      tick("restart_seq", 13, 1);
      halt_a = 1;
      tick("halt_seq", 14, 0);
      halt_a = 0;
      tick("halt_hold", 14, 0);
      reset = 1;
      tick("t6_reset_in_halt", 0, 0);
      check("t6_redir_cnt_clr", redir_a, 32'd0);
      check("t6_stall_cnt_clr", stall_a, 32'd0);
      reset = 0; bus_a.bt = 1; bus_a.imm_b = 32'd4;
      tick("idle_ignores_br", 0, 0);

      // Reset in the middle of a stall discards the pending redirect.
      clr_bus(); start_a = 1;
      tick("rs_start", 0, 1);
      start_a = 0; bus_a.stall = 1; bus_a.jt_r = 1; bus_a.jlr = 32'd40;
      tick("rs_stall", 0, 1);
      reset = 1;
      tick("rs_reset", 0, 0);
      reset = 0; clr_bus(); start_a = 1;
      tick("rs_restart", 0, 1);
      start_a = 0;
      tick("rs_no_pend", 1, 1);

      // Misaligned targets on the STEP=4, ALIGN_BITS=2 instance.
      cur_sel = 1'b1; exp_bad = '0;
      start_b = 1;
      tick("b_start", 0, 1);
      start_b = 0;
      tick("b_seq", 4, 1);
      bus_b.jt_r = 1; bus_b.jlr = 32'h102; exp_bad = 32'h102;
      tick("t4_trap", 4, 0, 1);
      clr_bus();
      tick("t4_trap_exit", 4, 1);
      tick("t4_run_on", 8, 1);
      bus_b.jt_r = 1; bus_b.jlr = 32'h200;
      tick("b_aligned", 32'h200, 1);
      clr_bus(); bus_b.bt = 1; bus_b.imm_b = 32'd6; exp_bad = 32'h206;
      tick("b_br_trap", 4, 0, 1);
      clr_bus();
      tick("b_br_exit", 4, 1);
      tick("b_seq2", 8, 1);
      bus_b.stall = 1; bus_b.jt_j = 1; bus_b.imm_j = 32'd1;
      tick("b_pend_hold", 8, 1);
      clr_bus(); exp_bad = 32'h9;
      tick("b_pend_trap", 4, 0, 1);
      tick("b_pend_exit", 4, 1);
      check("b_redir_cnt", redir_b, perf(4));
      check("b_stall_cnt", stall_b, perf(1));

      repeat (3) @(posedge clock);
      #2;
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
